mux_onehot_buf: RTL and testbench
=================================

// Module: mux_onehot_buf
// PURPOSE
//  Parametrised N-channel, W-bit one-hot AND-OR operand mux for the multi-cycle CPU datapath.
//  Registered, 2-entry skid-buffered output with valid/ready handshake on both sides.
//  Flags illegal selects with a sticky error.
//  Replaces the chains of per-bit 2-input select gates in front of the ALU/PC/memory operand paths.
// PARAMETERS
//  WIDTH     32  data bits per channel (>=1)
//  CHANNELS  4   number of input channels (>=2); sel is one bit per channel
// PORTS
//  clk      in   1               system clock, all state on rising edge
//  rst      in   1               synchronous reset, active-high
//  in_data  in   CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  sel      in   CHANNELS        one-hot channel select, sampled with in_data
//  in_valid in   1               upstream presents in_data/sel
//  in_ready out  1               block accepts this cycle
//  out_data out  WIDTH           head-of-buffer muxed word
//  out_valid out 1               out_data valid
//  out_ready in  1               downstream consumes this cycle
//  sel_err  out  1               sticky: an illegal sel was accepted
//  err_clr  in   1               clears sel_err
// BEHAVIOUR
//  - Reset: count=0, out_valid=0, out_data=0, sel_err=0; in_ready=1 in the first cycle after reset.
//  - Reset during any transfer discards buffered words; no partial state survives.
//  - Combine (default): word = OR over k of (in_data[k] & {WIDTH{sel[k]}}).
//    sel=0 gives word 0; multi-hot gives the bitwise OR of the selected channels.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count!=2), a function of registered state only; no comb path from out_ready.
//  - out_valid = (count!=0). Latency: word accepted at edge N is visible at out_data after edge N.
//  - Buffer states by count:
//    - EMPTY(0): push -> ONE.
//    - ONE(1):
//      - push & !pop -> TWO (new word to skid slot).
//      - push & pop -> ONE (head <= new word).
//      - pop only -> EMPTY.
//    - TWO(2): in_ready=0; pop -> ONE, skid slot moves to head.
//  - Ordering is strict FIFO. out_data holds stable while out_valid & !out_ready.
//  - out_data keeps its last value when EMPTY; it is never zeroed after reset.
//  - sel_err set at edge where push & illegal(sel); illegal = sel==0 or popcount(sel)>1.
//    Set and err_clr in the same cycle: set wins.
//  - in_valid=0 means sel/in_data are ignored; no error is raised for them.
// CONFIGURATION
//  MUX_PRIORITY_EN defined:
//    - Multi-hot sel resolves to the lowest-index set bit; only that channel passes.
//    - Multi-hot is legal; illegal = sel==0 only.
//  MUX_PRIORITY_EN undefined: OR-combine and error rules exactly as in BEHAVIOUR.
//  Handshake, latency and buffer behaviour are identical in both builds.
// TESTING (WIDTH=8, CHANNELS=4 unless stated)
//  1. rst=1 for 2 cycles, then idle
//     -> out_valid=0, out_data=0, sel_err=0, in_ready=1.
//  2. in_data={8'h44,8'h33,8'h22,8'h11}, sel=4'b0100, in_valid=1 for 1 cycle, out_ready=1
//     -> next cycle out_data=8'h33, out_valid=1; following cycle out_valid=0.
//  3. out_ready=0; push words for sel=0001,0010,0100 on consecutive cycles
//     -> in_ready drops after 2 accepts, third word held upstream.
//     Then out_ready=1 -> outputs 11,22,33 in order, no loss or duplication.
//  4. sel=4'b0011 accepted, data as in 2
//     -> default build: out_data=8'h33 (11|22), sel_err=1.
//     MUX_PRIORITY_EN build: out_data=8'h11, sel_err=0.
//  5. sel=4'b0000 accepted -> out_data=0, sel_err=1.
//     err_clr=1 alone clears it. err_clr with a second illegal push -> sel_err stays 1.
//  6. count=2 with rst=1 asserted mid-stream -> next cycle out_valid=0, in_ready=1.
//     The next pushed word is the first word out.

Source files
------------

// File: rtl/mux_onehot_buf_if.sv
// Handshake bundle for mux_onehot_buf: upstream operand channels plus the
// downstream buffered word and the sticky select-error flag.
interface mux_onehot_buf_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    // Valid/ready: a word moves across a side on every rising clk edge where
    // valid and ready are both high. The sender holds data stable while valid is
    // high and ready is low. in_ready depends on registered state only, and
    // out_valid never depends on out_ready.
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;
    logic                      err_clr;

    modport master (
        output in_data,
        output sel,
        output in_valid,
        output out_ready,
        output err_clr,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  sel_err
    );

    modport slave (
        input  in_data,
        input  sel,
        input  in_valid,
        input  out_ready,
        input  err_clr,
        output in_ready,
        output out_data,
        output out_valid,
        output sel_err
    );
endinterface

// File: rtl/mux_onehot_buf.sv
// One-hot AND-OR operand mux with a 2-entry skid-buffered registered output.
// Define MUX_PRIORITY_EN to resolve multi-hot selects to the lowest set index.
module mux_onehot_buf #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_onehot_buf_if.slave   bus,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam logic [CHANNELS-1:0] SEL_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    buf_state_t       state;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             err_q;
    logic [WIDTH-1:0] word;
    logic             illegal;
    logic             push;
    logic             pop;

`ifdef MUX_PRIORITY_EN
    logic found;

    always_comb begin
        word  = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.sel[k] && !found) begin
                word  = bus.in_data[k*WIDTH +: WIDTH];
                found = 1'b1;
            end
        end
    end

    assign illegal = (bus.sel == '0);
`else
    always_comb begin
        word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            word = word | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{bus.sel[k]}});
        end
    end

    // Clearing the lowest set bit leaves something behind only when multi-hot.
    assign illegal = (bus.sel == '0) || ((bus.sel & (bus.sel - SEL_ONE)) != '0);
`endif

    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = head_q;
    assign bus.sel_err   = err_q;
    assign state_dbg     = state;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= word;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q <= word;
                        state  <= TWO;
                    end else if (push && pop) begin
                        head_q <= word;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // Full: the skid word becomes the head; no push is possible here.
                    if (pop) begin
                        head_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase

            if (push && illegal) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_onehot_buf.sv
// Directed bench for mux_onehot_buf at WIDTH=8, CHANNELS=4.
module tb_mux_onehot_buf;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         errors;
    int         checks;

    mux_onehot_buf_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    mux_onehot_buf #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%b exp=0", bus.sel_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_single();
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.sel       = 4'b0100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== 8'h33) begin errors++; $display("FAIL single_data got=%h exp=33", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h33) begin errors++; $display("FAIL single_hold_empty got=%h exp=33", bus.out_data); end
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL single_sel_err got=%b exp=0", bus.sel_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int         budget;
        exp_q = {8'h11, 8'h22, 8'h33};
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 4'b0001;
        tick();
        bus.sel = 4'b0010;
        tick();
        bus.sel = 4'b0100;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL fill_state got=%0d exp=2", state_dbg); end
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL stall_hold got=%h exp=11", bus.out_data); end
        bus.out_ready = 1'b1;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            logic pushed;
            pushed = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                logic [7:0] exp_w;
                exp_w = exp_q.pop_front();
                checks++; if (bus.out_data !== exp_w) begin errors++; $display("FAIL drain_order got=%h exp=%h", bus.out_data, exp_w); end
            end
            tick();
            if (pushed) bus.in_valid = 1'b0;
            budget--;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size()); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_no_dup got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_multi_hot();
        bus.out_ready = 1'b1;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.sel       = 4'b0011;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
`ifdef MUX_PRIORITY_EN
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL multi2_data got=%h exp=11", bus.out_data); end
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL multi2_err got=%b exp=0", bus.sel_err); end
`else
        checks++; if (bus.out_data !== 8'h33) begin errors++; $display("FAIL multi2_data got=%h exp=33", bus.out_data); end
        checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL multi2_err got=%b exp=1", bus.sel_err); end
`endif
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        bus.sel      = 4'b1111;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
`ifdef MUX_PRIORITY_EN
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL multi4_data got=%h exp=11", bus.out_data); end
`else
        checks++; if (bus.out_data !== 8'h77) begin errors++; $display("FAIL multi4_data got=%h exp=77", bus.out_data); end
`endif
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL multi_clr got=%b exp=0", bus.sel_err); end
    endtask

    task automatic test_sel_zero();
        bus.out_ready = 1'b1;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.sel       = 4'b0000;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL zero_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL zero_err got=%b exp=1", bus.sel_err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL zero_clr got=%b exp=0", bus.sel_err); end
        tick();
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL zero_idle_ignored got=%b exp=0", bus.sel_err); end
        bus.in_valid = 1'b1;
        bus.err_clr  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL zero_set_wins got=%b exp=1", bus.sel_err); end
        bus.sel      = 4'b1000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL zero_sticky got=%b exp=1", bus.sel_err); end
        checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL zero_next_data got=%h exp=44", bus.out_data); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = 1'b1;
        bus.sel       = 4'b0001;
        tick();
        bus.sel = 4'b0010;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL mid_full got=%0d exp=2", state_dbg); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data got=%h exp=00", bus.out_data); end
        bus.sel      = 4'b1000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL mid_first_out got=%h exp=44", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_first_valid got=%b exp=1", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_multi_hot();
        test_sel_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
